ntt_stage_ctrl: RTL and testbench

Sequencer for the radix-2 butterfly datapath of a single N-point NTT over a dual-read/dual-write coefficient memory. For every stage it issues one butterfly per cycle: coefficient pair read addresses, twiddle ROM address, the butterfly `bf_valid` strobe, and the delayed write-back addresses. Between stages it drains the pipeline so read-after-write hazards cannot occur. It sits between the host start/done interface and the butterfly unit, which performs modular add/sub with Barrett-reduced multiply.

---
 rtl/ntt_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: stage/butterfly sequencer for a radix-2 N-point NTT.
// Issues one coefficient-pair read per cycle with its twiddle index. The read
// addresses are delayed through a (1+BF_LAT)-deep valid/address pipe that
// produces the write-back strobe. The pipe drains between stages.
// Optional feature macro: NTT_CTRL_INTT_EN (inverse stage order + twiddle offset).
module ntt_stage_ctrl #(
   parameter int LOGN     = 4,
   parameter int BF_LAT   = 2,
   parameter int BIT_SIZE = 60
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                inverse,
   input  logic [BIT_SIZE-1:0] cfg_q,
   input  logic                hold,
   output logic                busy,
   output logic                done,
   output logic [BIT_SIZE-1:0] q_o,
   output logic                rd_en,
   output logic [LOGN-1:0]     rd_addr0,
   output logic [LOGN-1:0]     rd_addr1,
   output logic [LOGN-1:0]     tw_addr,
   output logic                bf_valid,
   output logic                wr_en,
   output logic [LOGN-1:0]     wr_addr0,
   output logic [LOGN-1:0]     wr_addr1,
   output logic [LOGN-1:0]     stage_o
);

   localparam int unsigned     PD     = 1 + BF_LAT;
   localparam logic [LOGN-1:0] LAST_S = LOGN'(LOGN - 1);
   localparam logic [LOGN-1:0] ONE    = LOGN'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [LOGN-2:0]       b_q, b_d;
   logic [LOGN-1:0]       s_q, s_d;
   logic [BIT_SIZE-1:0]   q_q;
   logic [LOGN-1:0]       first_s, last_s, next_s;
   logic [LOGN-1:0]       bx, mask, o, idx0, idx1, tw;
   logic [PD-1:0]         vld_q;
   logic [LOGN-1:0]       a0_q [PD];
   logic [LOGN-1:0]       a1_q [PD];

`ifdef NTT_CTRL_INTT_EN
   localparam logic [LOGN-1:0] HALF = LOGN'(1) << (LOGN - 1);
   logic inv_q;

   // Stage ordering; the first stage depends on the live request at start.
   always_comb begin
      first_s = inverse ? LAST_S : '0;
      last_s  = inv_q ? '0 : LAST_S;
      next_s  = inv_q ? (s_q - ONE) : (s_q + ONE);
   end

   // Capture the transform direction with start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                        inv_q <= 1'b0;
      else if (state_q == IDLE && start) inv_q <= inverse;
   end
`else
   logic unused_inverse;
   assign unused_inverse = inverse;

   // Forward-only stage ordering.
   always_comb begin
      first_s = '0;
      last_s  = LAST_S;
      next_s  = s_q + ONE;
   end
`endif

   // State register with butterfly/stage counters and captured modulus.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         b_q     <= '0;
         s_q     <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         s_q     <= s_d;
         if (state_q == IDLE && start) q_q <= cfg_q;
      end
   end

   // Next-state logic: issue N/2 butterflies, drain the pipe, then advance.
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               b_d     = '0;
               s_d     = first_s;
            end
         end
         ISSUE: begin
            if (!hold) begin
               // b wraps to 0 after the last butterfly, ready for the next stage
               b_d = b_q + 1'b1;
               if (b_q == '1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // leave once only the final write remains in the pipe
            if (vld_q[PD-2:0] == '0) begin
               if (s_q == last_s) begin
                  state_d = DONE;
               end else begin
                  s_d     = next_s;
                  state_d = ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy  = (state_q == ISSUE) || (state_q == DRAIN);
      done  = (state_q == DONE);
      rd_en = (state_q == ISSUE) && !hold;
   end

   // Butterfly address generation; a zero bit is inserted at position s.
   always_comb begin
      bx   = LOGN'(b_q);
      mask = (ONE << s_q) - ONE;
      o    = bx & mask;
      idx0 = ((bx >> s_q) << (s_q + ONE)) | o;
      idx1 = idx0 + (ONE << s_q);
      tw   = o << (LAST_S - s_q);
`ifdef NTT_CTRL_INTT_EN
      if (inv_q) tw = tw + HALF;
`endif
      rd_addr0 = rd_en ? idx0 : '0;
      rd_addr1 = rd_en ? idx1 : '0;
      tw_addr  = rd_en ? tw   : '0;
   end

   // Read-to-write delay pipe; async reset kills any pending write at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         a0_q  <= '{default: '0};
         a1_q  <= '{default: '0};
      end else begin
         vld_q   <= {vld_q[PD-2:0], rd_en};
         a0_q[0] <= rd_addr0;
         a1_q[0] <= rd_addr1;
         for (int unsigned i = 1; i < PD; i++) begin
            a0_q[i] <= a0_q[i-1];
            a1_q[i] <= a1_q[i-1];
         end
      end
   end

   assign q_o      = q_q;
   assign bf_valid = vld_q[0];
   assign wr_en    = vld_q[PD-1];
   assign wr_addr0 = a0_q[PD-1];
   assign wr_addr1 = a1_q[PD-1];
   assign stage_o  = s_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl at default parameters (LOGN=4, BF_LAT=2).
// Cycle c is the interval after the c-th rising edge following the start edge.
module tb_ntt_stage_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        inverse = 1'b0;
   logic [59:0] cfg_q = 60'h0FF_FFFF_0000_0001;
   logic        hold = 1'b0;
   logic        busy, done, rd_en, bf_valid, wr_en;
   logic [59:0] q_o;
   logic [3:0]  rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1, stage_o;

   int checks = 0;
   int failures = 0;

   logic       r_rd [0:127];
   logic       r_wr [0:127];
   logic       r_bfv[0:127];
   logic       r_busy[0:127];
   logic       r_done[0:127];
   logic [3:0] r_a0 [0:127];
   logic [3:0] r_a1 [0:127];
   logic [3:0] r_tw [0:127];
   logic [3:0] r_w0 [0:127];
   logic [3:0] r_w1 [0:127];
   logic [3:0] r_st [0:127];

   ntt_stage_ctrl #(.LOGN(4), .BF_LAT(2), .BIT_SIZE(60)) dut (
      .clk(clk), .rstn(rstn), .start(start), .inverse(inverse), .cfg_q(cfg_q),
      .hold(hold), .busy(busy), .done(done), .q_o(q_o), .rd_en(rd_en),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
      .bf_valid(bf_valid), .wr_en(wr_en), .wr_addr0(wr_addr0),
      .wr_addr1(wr_addr1), .stage_o(stage_o)
   );

   always #5 clk = ~clk;

   // Reads with no hold: four stages of 11 cycles, 8 reads at the start of each.
   function automatic bit base_rd(input int c);
      if (c < 1) return 1'b0;
      return ((c - 1) / 11 < 4) && ((c - 1) % 11 < 8);
   endfunction

   // A hold window of hn cycles starting at hlo removes reads there and shifts the rest.
   function automatic bit sched_rd(input int c, input int hlo, input int hn);
      if (hn > 0 && c >= hlo && c < hlo + hn) return 1'b0;
      if (hn > 0 && c >= hlo + hn) return base_rd(c - hn);
      return base_rd(c);
   endfunction

   function automatic logic [3:0] m_idx0(input int s, input int b);
      int m;
      m = 1 << s;
      return 4'((b / m) * 2 * m + (b % m));
   endfunction

   function automatic logic [3:0] m_idx1(input int s, input int b);
      return 4'(int'(m_idx0(s, b)) + (1 << s));
   endfunction

   function automatic logic [3:0] m_tw(input int s, input int b, input bit inv);
      int v;
      v = (b % (1 << s)) * (8 >> s);
      if (inv) v = (v + 8) % 16;
      return 4'(v);
   endfunction

   task automatic run_xfer(input int hlo, input int hhi, input int sa, input int sb,
                           input logic inv, input int ncyc);
      @(negedge clk);
      start = 1'b1;
      inverse = inv;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         hold  = (c >= hlo) && (c <= hhi);
         start = (c == sa) || (c == sb);
         @(negedge clk);
         r_rd[c] = rd_en;   r_wr[c] = wr_en;    r_bfv[c] = bf_valid;
         r_busy[c] = busy;  r_done[c] = done;
         r_a0[c] = rd_addr0; r_a1[c] = rd_addr1; r_tw[c] = tw_addr;
         r_w0[c] = wr_addr0; r_w1[c] = wr_addr1; r_st[c] = stage_o;
         @(posedge clk);
         #1;
      end
      hold = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #3;
      checks++;
      if ({busy, done, q_o, rd_en, rd_addr0, rd_addr1, tw_addr, bf_valid, wr_en,
           wr_addr0, wr_addr1, stage_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b wr_en=%b q=%0h stage=%0d exp all 0",
                  busy, done, rd_en, wr_en, q_o, stage_o);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got busy=%b rd_en=%b exp 0 0", busy, rd_en);
      end
   endtask

   task automatic test_basic();
      int s, b, sw, bw;
      run_xfer(0, 0, 0, 0, 1'b0, 50);
      for (int c = 1; c <= 50; c++) begin
         checks++;
         if (r_rd[c] !== base_rd(c)) begin
            failures++; $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, r_rd[c], base_rd(c));
         end
         checks++;
         if (r_bfv[c] !== base_rd(c - 1)) begin
            failures++; $display("FAIL basic_bf_valid c=%0d got=%b exp=%b", c, r_bfv[c], base_rd(c - 1));
         end
         checks++;
         if (r_wr[c] !== base_rd(c - 3)) begin
            failures++; $display("FAIL basic_wr_en c=%0d got=%b exp=%b", c, r_wr[c], base_rd(c - 3));
         end
         checks++;
         if (r_busy[c] !== (c <= 44)) begin
            failures++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, r_busy[c], c <= 44);
         end
         checks++;
         if (r_done[c] !== (c == 45)) begin
            failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, r_done[c], c == 45);
         end
         if (base_rd(c)) begin
            s = (c - 1) / 11;
            b = (c - 1) % 11;
            checks++;
            if (r_a0[c] !== m_idx0(s, b) || r_a1[c] !== m_idx1(s, b) ||
                r_tw[c] !== m_tw(s, b, 1'b0) || r_st[c] !== 4'(s)) begin
               failures++;
               $display("FAIL basic_rd_addr c=%0d got=%0d/%0d tw=%0d st=%0d exp=%0d/%0d tw=%0d st=%0d",
                        c, r_a0[c], r_a1[c], r_tw[c], r_st[c],
                        m_idx0(s, b), m_idx1(s, b), m_tw(s, b, 1'b0), s);
            end
         end
         if (base_rd(c - 3)) begin
            sw = (c - 4) / 11;
            bw = (c - 4) % 11;
            checks++;
            if (r_w0[c] !== m_idx0(sw, bw) || r_w1[c] !== m_idx1(sw, bw)) begin
               failures++;
               $display("FAIL basic_wr_addr c=%0d got=%0d/%0d exp=%0d/%0d",
                        c, r_w0[c], r_w1[c], m_idx0(sw, bw), m_idx1(sw, bw));
            end
         end
      end
      // Hand-computed address points.
      checks++;
      if (r_a0[2] !== 4'd2 || r_a1[2] !== 4'd3 || r_tw[2] !== 4'd0) begin
         failures++; $display("FAIL addr_s0_b1 got=%0d/%0d tw=%0d exp=2/3 tw=0", r_a0[2], r_a1[2], r_tw[2]);
      end
      checks++;
      if (r_a0[15] !== 4'd5 || r_a1[15] !== 4'd7 || r_tw[15] !== 4'd4) begin
         failures++; $display("FAIL addr_s1_b3 got=%0d/%0d tw=%0d exp=5/7 tw=4", r_a0[15], r_a1[15], r_tw[15]);
      end
      checks++;
      if (r_a0[39] !== 4'd5 || r_a1[39] !== 4'd13 || r_tw[39] !== 4'd5 || r_st[39] !== 4'd3) begin
         failures++; $display("FAIL addr_s3_b5 got=%0d/%0d tw=%0d st=%0d exp=5/13 tw=5 st=3",
                              r_a0[39], r_a1[39], r_tw[39], r_st[39]);
      end
      checks++;
      if (r_w0[42] !== 4'd5 || r_w1[42] !== 4'd13) begin
         failures++; $display("FAIL wr_s3_b5 got=%0d/%0d exp=5/13", r_w0[42], r_w1[42]);
      end
      checks++;
      if (q_o !== 60'h0FF_FFFF_0000_0001) begin
         failures++; $display("FAIL q_capture got=%0h exp=%0h", q_o, 60'h0FF_FFFF_0000_0001);
      end
   endtask

   task automatic test_hold();
      run_xfer(3, 5, 0, 0, 1'b0, 52);
      for (int c = 1; c <= 52; c++) begin
         checks++;
         if (r_rd[c] !== sched_rd(c, 3, 3)) begin
            failures++; $display("FAIL hold_rd_en c=%0d got=%b exp=%b", c, r_rd[c], sched_rd(c, 3, 3));
         end
         checks++;
         if (r_wr[c] !== sched_rd(c - 3, 3, 3)) begin
            failures++; $display("FAIL hold_wr_en c=%0d got=%b exp=%b", c, r_wr[c], sched_rd(c - 3, 3, 3));
         end
         checks++;
         if (r_busy[c] !== (c <= 47) || r_done[c] !== (c == 48)) begin
            failures++; $display("FAIL hold_busy_done c=%0d got=%b/%b exp=%b/%b",
                                 c, r_busy[c], r_done[c], c <= 47, c == 48);
         end
      end
      checks++;
      if (r_a0[6] !== 4'd4 || r_a1[6] !== 4'd5) begin
         failures++; $display("FAIL hold_b_frozen got=%0d/%0d exp=4/5", r_a0[6], r_a1[6]);
      end
      checks++;
      if (r_w0[9] !== 4'd4 || r_w1[9] !== 4'd5) begin
         failures++; $display("FAIL hold_wr_after got=%0d/%0d exp=4/5", r_w0[9], r_w1[9]);
      end
   endtask

   task automatic test_reset_midrun();
      int nrd, nwr, nbusy;
      @(negedge clk);
      start = 1'b1;
      inverse = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      checks++;
      if (wr_en !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL midrun_pre got wr_en=%b busy=%b exp 1 1", wr_en, busy);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({busy, done, q_o, rd_en, rd_addr0, rd_addr1, tw_addr, bf_valid, wr_en,
           wr_addr0, wr_addr1, stage_o} !== '0) begin
         failures++;
         $display("FAIL midrun_reset_outputs got busy=%b wr_en=%b bfv=%b stage=%0d q=%0h exp all 0",
                  busy, wr_en, bf_valid, stage_o, q_o);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++; $display("FAIL midrun_no_partial got wr_en=%b busy=%b rd_en=%b exp 0 0 0",
                                 wr_en, busy, rd_en);
         end
      end
      run_xfer(0, 0, 0, 0, 1'b0, 50);
      nrd = 0; nwr = 0; nbusy = 0;
      for (int c = 1; c <= 50; c++) begin
         nrd += int'(r_rd[c]);
         nwr += int'(r_wr[c]);
         nbusy += int'(r_busy[c]);
         checks++;
         if (r_done[c] !== (c == 45)) begin
            failures++; $display("FAIL rerun_done c=%0d got=%b exp=%b", c, r_done[c], c == 45);
         end
      end
      checks++;
      if (nrd != 32 || nwr != 32 || nbusy != 44) begin
         failures++; $display("FAIL rerun_counts got rd=%0d wr=%0d busy=%0d exp 32 32 44", nrd, nwr, nbusy);
      end
      checks++;
      if (r_a0[39] !== 4'd5 || r_a1[39] !== 4'd13) begin
         failures++; $display("FAIL rerun_addr got=%0d/%0d exp=5/13", r_a0[39], r_a1[39]);
      end
   endtask

   task automatic test_start_ignored();
      int ndone, nrd;
      run_xfer(0, 0, 5, 45, 1'b0, 70);
      ndone = 0; nrd = 0;
      for (int c = 1; c <= 70; c++) begin
         ndone += int'(r_done[c]);
         nrd += int'(r_rd[c]);
         checks++;
         if (r_busy[c] !== (c <= 44)) begin
            failures++; $display("FAIL ignore_busy c=%0d got=%b exp=%b", c, r_busy[c], c <= 44);
         end
      end
      checks++;
      if (ndone != 1 || r_done[45] !== 1'b1) begin
         failures++; $display("FAIL ignore_done got count=%0d at45=%b exp 1 1", ndone, r_done[45]);
      end
      checks++;
      if (nrd != 32) begin
         failures++; $display("FAIL ignore_reads got=%0d exp=32", nrd);
      end
   endtask

   task automatic test_inverse();
      int s, b;
      bit inv;
`ifdef NTT_CTRL_INTT_EN
      inv = 1'b1;
`else
      inv = 1'b0;
`endif
      run_xfer(0, 0, 0, 0, 1'b1, 50);
      for (int c = 1; c <= 44; c++) begin
         if (base_rd(c)) begin
            s = inv ? 3 - (c - 1) / 11 : (c - 1) / 11;
            b = (c - 1) % 11;
            checks++;
            if (r_a0[c] !== m_idx0(s, b) || r_a1[c] !== m_idx1(s, b) ||
                r_tw[c] !== m_tw(s, b, inv) || r_st[c] !== 4'(s)) begin
               failures++;
               $display("FAIL inv_rd_addr c=%0d got=%0d/%0d tw=%0d st=%0d exp=%0d/%0d tw=%0d st=%0d",
                        c, r_a0[c], r_a1[c], r_tw[c], r_st[c],
                        m_idx0(s, b), m_idx1(s, b), m_tw(s, b, inv), s);
            end
         end
      end
`ifdef NTT_CTRL_INTT_EN
      checks++;
      if (r_st[1] !== 4'd3 || r_a0[1] !== 4'd0 || r_a1[1] !== 4'd8 || r_tw[1] !== 4'd8 || r_st[34] !== 4'd0) begin
         failures++; $display("FAIL inv_first_last got st=%0d rd=%0d/%0d tw=%0d last_st=%0d exp 3 0/8 8 0",
                              r_st[1], r_a0[1], r_a1[1], r_tw[1], r_st[34]);
      end
`else
      checks++;
      if (r_st[1] !== 4'd0 || r_a0[1] !== 4'd0 || r_a1[1] !== 4'd1 || r_tw[1] !== 4'd0 || r_st[34] !== 4'd3) begin
         failures++; $display("FAIL inv_ignored got st=%0d rd=%0d/%0d tw=%0d last_st=%0d exp 0 0/1 0 3",
                              r_st[1], r_a0[1], r_a1[1], r_tw[1], r_st[34]);
      end
`endif
      checks++;
      if (r_done[45] !== 1'b1 || r_busy[44] !== 1'b1) begin
         failures++; $display("FAIL inv_done got done45=%b busy44=%b exp 1 1", r_done[45], r_busy[44]);
      end
      inverse = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_reset_midrun();
      test_start_ignored();
      test_inverse();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete got=running exp=finished");
      $fatal(1);
   end

endmodule
